fir_tap_scheduler: RTL and testbench

- Time-multiplexed controller for the 5-tap shift-coefficient FIR.
- Accepts one 16-bit sample per handshake and shifts it into a tap delay line.
- Sequences a single shared 16-bit prefix adder across all taps, one tap per cycle, then presents the filtered result on a valid/ready output.
- Replaces the four-adder unrolled filter where area matters more than throughput.

---
 rtl/fir_pkg.sv | 19 +
 rtl/prefix_add16.sv | 47 ++++
 rtl/fir_tap_scheduler.sv | 118 +++++++++++
 tb/tb_fir_tap_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared defaults, FSM state encoding and tap shift rule for the
// time-multiplexed shift-coefficient FIR.
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_NTAPS  = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } fir_state_e;

  // Tap k (k=0 newest) is weighted by a right shift of ntaps-k.
  function automatic int tap_shift(input int k, input int ntaps = FIR_NTAPS);
    return ntaps - k;
  endfunction

endpackage

// File: rtl/prefix_add16.sv
// Sklansky parallel-prefix adder, 16 bits by default, carry-out not produced.
module prefix_add16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] Sum
);

  // Only bits 0..W-2 feed a carry into a higher bit, so the tree spans W-1 bits.
  localparam int TW = W - 1;
  localparam int L  = $clog2(TW);

  logic [W-1:0]  w_pBit;
  logic [W-1:0]  w_carry;

  assign w_pBit = A ^ B;

  for (genvar l = 0; l <= L; l++) begin : gLvl
    logic [TW-1:0] w_g;
    logic [TW-1:0] w_p;
    if (l == 0) begin : gBase
      assign w_g = A[TW-1:0] & B[TW-1:0];
      assign w_p = w_pBit[TW-1:0];
    end else begin : gTree
      for (genvar i = 0; i < TW; i++) begin : gBit
        if (((i >> (l - 1)) & 1) == 1) begin : gComb
          localparam int J = ((i >> (l - 1)) << (l - 1)) - 1;
          assign w_g[i] = gLvl[l-1].w_g[i] | (gLvl[l-1].w_p[i] & gLvl[l-1].w_g[J]);
          assign w_p[i] = gLvl[l-1].w_p[i] & gLvl[l-1].w_p[J];
        end else begin : gPass
          assign w_g[i] = gLvl[l-1].w_g[i];
          assign w_p[i] = gLvl[l-1].w_p[i];
        end
      end
    end
  end

  assign w_carry[0] = Cin;
  for (genvar i = 1; i < W; i++) begin : gCarry
    assign w_carry[i] = gLvl[L].w_g[i-1] | (gLvl[L].w_p[i-1] & Cin);
  end

  assign Sum = w_pBit ^ w_carry;

endmodule

// File: rtl/fir_tap_scheduler.sv
// Time-multiplexed 5-tap shift-coefficient FIR: one shared prefix adder
// walks the tap delay line one tap per cycle, then offers the sum downstream.
module fir_tap_scheduler
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int NTAPS  = FIR_NTAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  fir_state_e        r_state;
  logic [DATA_W-1:0] r_dly [NTAPS];
  logic [DATA_W-1:0] r_acc;
  logic [IDX_W-1:0]  r_idx;
  logic              r_inReady;
  logic              r_outValid;
  logic              r_busy;

  logic [DATA_W-1:0] w_term;
  logic [DATA_W-1:0] w_sum;
  logic              w_accept;

  assign w_accept = in_valid && r_inReady;

  // Select the tap addressed by r_idx and apply its fixed coefficient shift.
  always_comb begin
    w_term = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_term = r_dly[k] >> tap_shift(k, NTAPS);
      end
    end
  end

  prefix_add16 #(
    .W(DATA_W)
  ) u_add (
    .A  (r_acc),
    .B  (w_term),
    .Cin(1'b0),
    .Sum(w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_dly[k] <= '0;
      end
    end else if (w_accept) begin
      r_dly[0] <= x;
      for (int k = 1; k < NTAPS; k++) begin
        r_dly[k] <= r_dly[k-1];
      end
    end
  end

  // in_ready is held low through reset and rises on the first cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_idx      <= '0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc     <= '0;
            r_idx     <= '0;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ACC;
          end else begin
            r_inReady <= 1'b1;
          end
        end
        ACC: begin
          r_acc <= w_sum;
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_W'(NTAPS - 1)) begin
            r_outValid <= 1'b1;
            r_state    <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign dataout   = r_acc;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Self-checking bench for fir_tap_scheduler against a sample-history model.
module tb_fir_tap_scheduler;

  localparam int DW = 16;
  localparam int NT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] x;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dataout;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  always #5 clk = ~clk;

  fir_tap_scheduler #(
    .DATA_W(DW),
    .NTAPS (NT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .x        (x),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dataout  (dataout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] hist [NT];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < NT; k++) hist[k] = '0;
  endfunction

  function automatic void modelPush(input logic [DW-1:0] v);
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
  endfunction

  // Unrolled filter: sum of x[n-k] >> (NT-k), modulo 2^DW.
  function automatic logic [DW-1:0] modelOut();
    logic [31:0] s;
    s = 0;
    for (int k = 0; k < NT; k++) s = s + (32'(hist[k]) >> (NT - k));
    return s[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample, wait for the accept, then wait for out_valid (lat = cycles after accept edge).
  task automatic applyStimulus(input logic [DW-1:0] val, output int lat);
    int n;
    n = 0;
    in_valid = 1'b1;
    x = val;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput("inReadyWait", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    x = DW'($urandom);
    modelPush(val);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("outValidRise", 32'(out_valid), 1);
  endtask

  task automatic runSample(input logic [DW-1:0] val, input bit haveExp, input logic [DW-1:0] expv,
                           input string tag);
    int lat;
    out_ready = 1'b1;
    applyStimulus(val, lat);
    checkOutput({tag, "_lat"}, 32'(lat), 5);
    if (haveExp) checkOutput({tag, "_data"}, 32'(dataout), 32'(expv));
    checkOutput({tag, "_model"}, 32'(dataout), 32'(modelOut()));
    checkOutput({tag, "_noIrWithOv"}, 32'(in_ready), 0);
    tick();
    checkOutput({tag, "_ovDrop"}, 32'(out_valid), 0);
    checkOutput({tag, "_irRise"}, 32'(in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int            lat;
  int            cyc;
  int            lastAcc;
  int            accepts;
  int            ovSeen;
  logic          rdy;
  logic [DW-1:0] xs;
  logic [DW-1:0] held;
  logic [DW-1:0] expQ;
  logic [DW-1:0] impIn  [6];
  logic [DW-1:0] impExp [6];
  logic [DW-1:0] stepExp[5];

  initial begin
    impIn   = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    impExp  = '{16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h0000};
    stepExp = '{16'h07FF, 16'h17FE, 16'h37FD, 16'h77FC, 16'hF7FB};
    rst = 1'b1;
    x = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    modelReset();

    // power-on reset
    tick();
    checkOutput("rstInReady", 32'(in_ready), 0);
    checkOutput("rstOutValid", 32'(out_valid), 0);
    checkOutput("rstData", 32'(dataout), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("postRstInReady", 32'(in_ready), 1);

    // impulse response
    for (int i = 0; i < 6; i++) runSample(impIn[i], 1'b1, impExp[i], $sformatf("impulse%0d", i));

    // step response
    for (int i = 0; i < 5; i++) runSample(16'hFFFF, 1'b1, stepExp[i], $sformatf("step%0d", i));

    // reset while stalled in OUT clears everything
    out_ready = 1'b0;
    applyStimulus(16'h1234, lat);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rstOutInReady", 32'(in_ready), 0);
    checkOutput("rstOutValid", 32'(out_valid), 0);
    checkOutput("rstOutData", 32'(dataout), 0);
    checkOutput("rstOutBusy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    modelReset();
    tick();
    checkOutput("relInReady", 32'(in_ready), 1);
    checkOutput("relOutValid", 32'(out_valid), 0);
    checkOutput("relData", 32'(dataout), 0);
    runSample(16'h8000, 1'b1, 16'h0400, "afterRst");

    // backpressure: 10 stalled cycles with ignored in_valid pulses
    out_ready = 1'b0;
    applyStimulus(DW'($urandom), lat);
    held = modelOut();
    checkOutput("bpData", 32'(dataout), 32'(held));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      x = DW'($urandom);
      tick();
      checkOutput("bpHoldData", 32'(dataout), 32'(held));
      checkOutput("bpHoldValid", 32'(out_valid), 1);
      checkOutput("bpHoldInReady", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bpRelValid", 32'(out_valid), 0);
    checkOutput("bpRelInReady", 32'(in_ready), 1);
    ovSeen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) ovSeen++;
    end
    checkOutput("bpOneTransfer", 32'(ovSeen), 0);
    runSample(DW'($urandom), 1'b0, '0, "afterBp");

    // continuous in_valid/out_ready: accept period and latency
    out_ready = 1'b1;
    in_valid = 1'b1;
    x = DW'($urandom);
    cyc = 0;
    lastAcc = -1;
    accepts = 0;
    expQ = '0;
    for (int c = 0; c < 63; c++) begin
      rdy = in_ready;
      xs = x;
      tick();
      cyc++;
      checkOutput("tputExclusive", 32'(in_ready & out_valid), 0);
      if (rdy) begin
        if (lastAcc >= 0) checkOutput("tputPeriod", 32'(cyc - lastAcc), 7);
        lastAcc = cyc;
        accepts++;
        modelPush(xs);
        expQ = modelOut();
        x = DW'($urandom);
      end
      if (out_valid) begin
        checkOutput("tputLat", 32'(cyc - lastAcc), 5);
        checkOutput("tputData", 32'(dataout), 32'(expQ));
      end
    end
    in_valid = 1'b0;
    checkOutput("tputAccepts", 32'(accepts), 9);

    // reset two cycles after an accept discards the partial sum
    checkOutput("midAccPreReady", 32'(in_ready), 1);
    in_valid = 1'b1;
    x = DW'($urandom);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midAccBusy", 32'(busy), 0);
    checkOutput("midAccInReady", 32'(in_ready), 0);
    checkOutput("midAccOutValid", 32'(out_valid), 0);
    tick();
    rst = 1'b0;
    modelReset();
    ovSeen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) ovSeen++;
    end
    checkOutput("midAccNoOutput", 32'(ovSeen), 0);
    runSample(16'h8000, 1'b1, 16'h0400, "midAccImpulse");

    // random samples against the model
    for (int i = 0; i < 20; i++) runSample(DW'($urandom), 1'b0, '0, $sformatf("rand%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
